// File: rtl/adder_sched.sv
// Request scheduler for an external adder datapath: arbitrates three requesters,
// issues one transaction at a time and returns the result. Define ADDER_SCHED_FIXED_PRIO_EN for fixed priority.
module adder_sched #(
   parameter int DP_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req_valid,
   input  logic [5:0]  req_mode,
   input  logic [95:0] req_data,
   output logic [2:0]  req_ready,
   output logic [1:0]  dp_enbl,
   output logic [7:0]  dp_in1,
   output logic [7:0]  dp_in2,
   output logic [7:0]  dp_in3,
   output logic [7:0]  dp_in4,
   input  logic [7:0]  dp_out,
   output logic [2:0]  rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam logic [1:0] LAST_CNT = 2'(DP_LAT);
   localparam logic [1:0] MODE_REJ = 2'd3;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [1:0]  winner_q, winner_d;
   logic [1:0]  mode_q, mode_d;
   logic [31:0] ops_q, ops_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;

   logic [1:0]  mode_arr [3];
   logic [31:0] data_arr [3];
   logic        grant_any;
   logic [1:0]  grant_idx;
   logic [2:0]  grant_oh;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
         assign mode_arr[gi] = req_mode[2*gi +: 2];
         assign data_arr[gi] = req_data[32*gi +: 32];
      end
   endgenerate

`ifdef ADDER_SCHED_FIXED_PRIO_EN
   always_comb begin
      grant_any = 1'b0;
      grant_idx = 2'd0;
      // Scan low priority first so the highest-priority valid requester wins.
      for (int k = 2; k >= 0; k--) begin
         if (req_valid[k]) begin
            grant_any = 1'b1;
            grant_idx = 2'(k);
         end
      end
   end
`else
   logic [2:0] rr_sum;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = 2'd0;
      rr_sum    = 3'd0;
      // Visit ptr+3 .. ptr+1 so the requester right after the pointer is written last and wins.
      for (int k = 3; k >= 1; k--) begin
         rr_sum = {1'b0, rr_ptr_q} + 3'(k);
         if (rr_sum >= 3'd3) begin
            rr_sum = rr_sum - 3'd3;
         end
         if (req_valid[rr_sum[1:0]]) begin
            grant_any = 1'b1;
            grant_idx = rr_sum[1:0];
         end
      end
   end
`endif

   assign grant_oh = 3'b001 << grant_idx;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rr_ptr_d   = rr_ptr_q;
      winner_d   = winner_q;
      mode_d     = mode_q;
      ops_d      = ops_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      req_ready  = 3'b000;

      case (state_q)
         IDLE: begin
            if (grant_any && rst) begin
               req_ready = grant_oh;
               winner_d  = grant_idx;
               rr_ptr_d  = grant_idx;
               if (mode_arr[grant_idx] == MODE_REJ) begin
                  // Rejected requests never reach the datapath; its drive is left untouched.
                  rsp_data_d = 8'h00;
                  rsp_err_d  = 1'b1;
                  state_d    = RESP;
               end else begin
                  mode_d  = mode_arr[grant_idx];
                  ops_d   = data_arr[grant_idx];
                  cnt_d   = 2'd0;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (cnt_q == LAST_CNT) begin
               rsp_data_d = dp_out;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         rr_ptr_q   <= 2'd2;
         winner_q   <= 2'd0;
         mode_q     <= 2'd0;
         ops_q      <= 32'd0;
         rsp_data_q <= 8'd0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         winner_q   <= winner_d;
         mode_q     <= mode_d;
         ops_q      <= ops_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign dp_enbl   = mode_q;
   assign dp_in1    = ops_q[7:0];
   assign dp_in2    = ops_q[15:8];
   assign dp_in3    = ops_q[23:16];
   assign dp_in4    = ops_q[31:24];
   assign rsp_valid = (state_q == RESP) ? (3'b001 << winner_q) : 3'b000;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule
